// File: rtl/imem_fetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// imem_fetch_ctrl_pkg
// Shared definitions for the instruction fetch controller:
//   - state_t      : controller state encoding (LOAD=0, RUN=1, HALT=2)
//   - NOP_INSTR    : instruction presented when no fetch is taking place
//   - DEFAULT_*    : default memory depth and start address
// ----------------------------------------------------------------------------
package imem_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam int          DEFAULT_DEPTH    = 64;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/imem_fetch_ctrl_pc_next_sel.sv
// ----------------------------------------------------------------------------
// imem_fetch_ctrl_pc_next_sel
// Next-PC selection for the RUN state.
// Ports:
//   pc            in  32  current fetch byte address
//   branch_taken  in  1   redirect request (highest priority)
//   branch_target in  32  redirect byte address, forced word aligned
//   stall         in  1   hold current PC
//   next_pc       out 32  selected next fetch byte address
// ----------------------------------------------------------------------------
module imem_fetch_ctrl_pc_next_sel (
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic [31:0] next_pc
);

  // Low target bits are dropped to keep fetches word aligned.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];

  // A branch wins over a stall; pc+4 wraps naturally at 2^32.
  always_comb begin
    next_pc = pc + 32'd4;
    if (branch_taken) begin
      next_pc = {branch_target[31:2], 2'b00};
    end else if (stall) begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// imem_fetch_ctrl
// Program-load and instruction-fetch controller for an external instruction
// memory with combinational read.
// Ports:
//   clk, rst                        clock / async active-high reset
//   ld_start, ld_valid, ld_data,
//   ld_done, ld_ready               program loader handshake
//   halt_req, stall,
//   branch_taken, branch_target     fetch control from the core
//   mem_addr, mem_wr_en,
//   mem_wr_data, mem_rd_data        instruction memory interface
//   pc, instr, instr_valid          fetch results
//   state                           current controller state
// ----------------------------------------------------------------------------
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_done,
  output logic              ld_ready,
  input  logic              halt_req,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  input  logic [31:0]       mem_rd_data,
  output logic [31:0]       pc,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [1:0]        state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] ld_cnt;
  logic [31:0]       next_pc;
  logic              in_load;
  logic              in_run;

  assign in_load = (state_q == ST_LOAD);
  assign in_run  = (state_q == ST_RUN);

  imem_fetch_ctrl_pc_next_sel u_pc_next_sel (
    .pc            (pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .next_pc       (next_pc)
  );

  // Memory and fetch outputs are combinational so a fetch completes in the
  // same cycle. A load write is suppressed while reset is asserted and when
  // ld_start restarts the load. Encoding 3 behaves as HALT.
  always_comb begin
    ld_ready    = in_load;
    mem_wr_data = ld_data;
    mem_wr_en   = in_load & ld_valid & ~ld_start & ~rst;
    mem_addr    = in_load ? ld_cnt : pc[ADDR_W+1:2];
    instr       = in_run ? mem_rd_data : NOP_INSTR;
    instr_valid = in_run & ~stall;
    state       = state_q;
  end

  // Controller state machine. ld_start has top priority in every state,
  // then halt_req, then the branch/stall/increment next-PC selection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      ld_cnt  <= '0;
      pc      <= RESET_PC;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (ld_start) begin
            ld_cnt <= '0;
          end else begin
            if (ld_valid) begin
              ld_cnt <= ld_cnt + 1'b1;
            end
            if (ld_done || (ld_valid && ld_cnt == LAST_ADDR)) begin
              state_q <= ST_RUN;
              pc      <= RESET_PC;
            end
          end
        end
        ST_RUN: begin
          if (ld_start) begin
            state_q <= ST_LOAD;
            ld_cnt  <= '0;
          end else if (halt_req) begin
            state_q <= ST_HALT;
          end else begin
            pc <= next_pc;
          end
        end
        default: begin
          if (ld_start) begin
            state_q <= ST_LOAD;
            ld_cnt  <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
// Directed bench for imem_fetch_ctrl with a behavioural 64-word memory.
// ----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        ld_start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_done;
  logic        ld_ready;
  logic        halt_req;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [5:0]  mem_addr;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [1:0]  state;

  int tests_run;
  int tests_failed;

  logic [31:0] mem [64];
  int          wr_count;

  imem_fetch_ctrl #(
    .DEPTH    (64),
    .ADDR_W   (6),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ld_start      (ld_start),
    .ld_valid      (ld_valid),
    .ld_data       (ld_data),
    .ld_done       (ld_done),
    .ld_ready      (ld_ready),
    .halt_req      (halt_req),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem_addr      (mem_addr),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_data   (mem_wr_data),
    .mem_rd_data   (mem_rd_data),
    .pc            (pc),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural instruction memory: synchronous write, combinational read.
  initial wr_count = 0;
  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_count      <= wr_count + 1;
    end
  end
  assign mem_rd_data = mem[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (state !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state got=%0d exp=0", state);
    end
    tests_run++;
    if (ld_ready !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs ld_ready=%b instr_valid=%b instr=%h exp 1/0/0",
               ld_ready, instr_valid, instr);
    end
    tests_run++;
    if (pc !== 32'h0 || mem_wr_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_pc_wr pc=%h mem_wr_en=%b exp 0/0", pc, mem_wr_en);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_load();
    logic [31:0] words [3];
    words[0] = 32'h2008_0005;
    words[1] = 32'h2009_0003;
    words[2] = 32'h0109_5020;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data  = words[i];
      #1;
      tests_run++;
      if (mem_addr !== 6'(i) || mem_wr_en !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL load_write%0d addr=%0d wr_en=%b exp addr=%0d wr_en=1",
                 i, mem_addr, mem_wr_en, i);
      end
      tick();
    end
    ld_valid = 1'b0;
    ld_done  = 1'b1;
    #1;
    tests_run++;
    if (mem_wr_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL done_no_write wr_en=%b exp=0", mem_wr_en);
    end
    tick();
    ld_done = 1'b0;
    #1;
    tests_run++;
    if (state !== 2'd1 || pc !== 32'h0 || instr !== 32'h2008_0005 || ld_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load_to_run state=%0d pc=%h instr=%h ld_ready=%b exp 1/0/20080005/0",
               state, pc, instr, ld_ready);
    end
    tests_run++;
    if (mem[1] !== 32'h2009_0003 || mem[2] !== 32'h0109_5020) begin
      tests_failed++;
      $display("[TB] FAIL load_contents mem1=%h mem2=%h exp 20090003/01095020", mem[1], mem[2]);
    end
  endtask

  task automatic test_run_seq();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (pc !== 32'(4 * i) || mem_addr !== 6'(i) || instr_valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL run_seq%0d pc=%h addr=%0d valid=%b exp pc=%h addr=%0d valid=1",
                 i, pc, mem_addr, instr_valid, 4 * i, i);
      end
      tick();
    end
  endtask

  task automatic test_branch_stall();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0030;
    tick();
    branch_taken = 1'b0;
    stall        = 1'b1;
    #1;
    tests_run++;
    if (pc !== 32'h30 || instr_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL branch_plain pc=%h valid=%b exp 30/0", pc, instr_valid);
    end
    tick();
    tests_run++;
    if (pc !== 32'h30) begin
      tests_failed++;
      $display("[TB] FAIL stall_hold pc=%h exp=30", pc);
    end
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0013;
    tick();
    branch_taken = 1'b0;
    stall        = 1'b0;
    #1;
    tests_run++;
    if (pc !== 32'h10 || mem_addr !== 6'd4) begin
      tests_failed++;
      $display("[TB] FAIL branch_over_stall pc=%h addr=%0d exp 10/4", pc, mem_addr);
    end
  endtask

  task automatic test_wrap();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_00FC;
    tick();
    branch_taken = 1'b0;
    #1;
    tests_run++;
    if (pc !== 32'hFC || mem_addr !== 6'd63) begin
      tests_failed++;
      $display("[TB] FAIL wrap_pre pc=%h addr=%0d exp FC/63", pc, mem_addr);
    end
    tick();
    tests_run++;
    if (pc !== 32'h100 || mem_addr !== 6'd0 || instr !== 32'h2008_0005) begin
      tests_failed++;
      $display("[TB] FAIL wrap_post pc=%h addr=%0d instr=%h exp 100/0/20080005",
               pc, mem_addr, instr);
    end
  endtask

  task automatic test_halt();
    halt_req = 1'b1;
    #1;
    tests_run++;
    if (instr_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL halt_cycle_valid valid=%b exp=1", instr_valid);
    end
    tick();
    halt_req = 1'b0;
    tick();
    tests_run++;
    if (state !== 2'd2 || pc !== 32'h100 || instr !== 32'h0 || instr_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL halted state=%0d pc=%h instr=%h valid=%b exp 2/100/0/0",
               state, pc, instr, instr_valid);
    end
  endtask

  task automatic test_full_load();
    int start_count;
    int bad_addr;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    #1;
    tests_run++;
    if (state !== 2'd0 || ld_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL halt_to_load state=%0d ld_ready=%b exp 0/1", state, ld_ready);
    end
    start_count = wr_count;
    bad_addr    = 0;
    for (int i = 0; i < 64; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'hA000_0000 + 32'(i);
      #1;
      if (mem_addr !== 6'(i)) bad_addr++;
      tick();
    end
    ld_valid = 1'b0;
    #1;
    tests_run++;
    if (bad_addr != 0 || (wr_count - start_count) != 64) begin
      tests_failed++;
      $display("[TB] FAIL full_load addr_errors=%0d writes=%0d exp 0/64",
               bad_addr, wr_count - start_count);
    end
    tests_run++;
    if (state !== 2'd1 || ld_ready !== 1'b0 || pc !== 32'h0 || mem[63] !== 32'hA000_003F) begin
      tests_failed++;
      $display("[TB] FAIL auto_run state=%0d ld_ready=%b pc=%h mem63=%h exp 1/0/0/a000003f",
               state, ld_ready, pc, mem[63]);
    end
  endtask

  task automatic test_priority_and_reset();
    halt_req = 1'b1;
    ld_start = 1'b1;
    tick();
    halt_req = 1'b0;
    #1;
    tests_run++;
    if (state !== 2'd0 || mem_addr !== 6'd0) begin
      tests_failed++;
      $display("[TB] FAIL start_over_halt state=%0d addr=%0d exp 0/0", state, mem_addr);
    end
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD_BEEF;
    #1;
    tests_run++;
    if (mem_wr_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL restart_discard wr_en=%b exp=0", mem_wr_en);
    end
    tick();
    ld_start = 1'b0;
    ld_data  = 32'h0000_1234;
    #1;
    tests_run++;
    if (mem_addr !== 6'd0 || mem_wr_en !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL restart_addr addr=%0d wr_en=%b exp 0/1", mem_addr, mem_wr_en);
    end
    ld_done = 1'b1;
    tick();
    ld_valid = 1'b0;
    ld_done  = 1'b0;
    #1;
    tests_run++;
    if (state !== 2'd1 || instr !== 32'h0000_1234 || mem[1] !== 32'hA000_0001) begin
      tests_failed++;
      $display("[TB] FAIL done_with_word state=%0d instr=%h mem1=%h exp 1/1234/a0000001",
               state, instr, mem[1]);
    end
    tick();
    tick();
    tests_run++;
    if (pc !== 32'h8) begin
      tests_failed++;
      $display("[TB] FAIL run_after_reload pc=%h exp=8", pc);
    end
    ld_valid = 1'b1;
    rst      = 1'b1;
    #1;
    tests_run++;
    if (state !== 2'd0 || pc !== 32'h0 || mem_wr_en !== 1'b0 || ld_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL async_reset state=%0d pc=%h wr_en=%b ld_ready=%b exp 0/0/0/1",
               state, pc, mem_wr_en, ld_ready);
    end
    ld_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    ld_start      = 1'b0;
    ld_valid      = 1'b0;
    ld_data       = 32'h0;
    ld_done       = 1'b0;
    halt_req      = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    test_reset();
    test_load();
    test_run_seq();
    test_branch_stall();
    test_wrap();
    test_halt();
    test_full_load();
    test_priority_and_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
